jups_fetch_pc: RTL and testbench

Program-counter and front-end stall block for the JupsCore single-cycle datapath. It sits directly upstream of the control unit: it holds the PC that addresses instruction memory and computes the next PC from the control unit's `Halt`, `Jump`, `Jal`, `Jr` and `branch` outputs. It also conditions the raw board push-button into a synchronised, optionally debounced, single-cycle press pulse. That pulse drives the control unit's `Button` input, so each `in`/`out` instruction is released exactly once per physical press.

---
 rtl/jups_fetch_pc.sv | 212 +++++++++++++++++++++
 tb/tb_jups_fetch_pc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jups_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : jups_fetch_pc
// Description : Program counter and front-end stall logic for the JupsCore
//               single-cycle datapath. Holds the instruction address, selects
//               the next PC from the control-unit strobes, and turns the raw
//               board push-button into a synchronised single-cycle press pulse.
//
// Ports
//   Clock        in   1         core clock, rising edge
//   Reset        in   1         asynchronous active-low reset
//   ButtonRaw    in   1         raw push-button, asynchronous, active-high
//   Halt         in   1         hold PC (highest priority)
//   Jump         in   1         absolute jump to Target (also set for jal)
//   Jal          in   1         jump-and-link; affects only the link path
//   Jr           in   1         jump to RegTarget
//   branch       in   1         conditional branch, taken when Zero is high
//   Zero         in   1         ALU equality flag
//   Target       in   PC_WIDTH  immediate jump/branch target
//   RegTarget    in   PC_WIDTH  register value for jr
//   PC           out  PC_WIDTH  current instruction address (registered)
//   LinkAddr     out  PC_WIDTH  PC+1, combinational, modulo 2^PC_WIDTH
//   ButtonPulse  out  1         one-cycle press pulse (control-unit Button)
//   Halted       out  1         Halt value sampled at the previous edge
//
// Configuration
//   JUPS_DEBOUNCE_EN  defined   : ARM/HELD counter FSM with DEB_CYCLES
//                     undefined : no counter, behaves as DEB_CYCLES = 1
//
// Revision    : 1.0 - initial release
// ============================================================================

module jups_fetch_pc #(
    parameter int          PC_WIDTH   = 10,
    parameter int unsigned RESET_PC   = 0,
    parameter int          DEB_CYCLES = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ButtonRaw,
    input  logic                Halt,
    input  logic                Jump,
    input  logic                Jal,
    input  logic                Jr,
    input  logic                branch,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] Target,
    input  logic [PC_WIDTH-1:0] RegTarget,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] LinkAddr,
    output logic                ButtonPulse,
    output logic                Halted
);

    localparam logic [PC_WIDTH-1:0] c_RESET_PC = PC_WIDTH'(RESET_PC);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HELD = 2'd2;

    // ------------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------------
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                r_halted;

    // Jal selects the return-register write elsewhere; the PC source is Jump.
    logic w_unused_jal;
    assign w_unused_jal = Jal;

    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    always_comb begin
        w_pc_next = w_pc_inc;
        if (Halt) begin
            w_pc_next = r_pc;
        end else if (Jr) begin
            w_pc_next = RegTarget;
        end else if (Jump) begin
            w_pc_next = Target;
        end else if (branch && Zero) begin
            w_pc_next = Target;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_pc     <= c_RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_pc     <= w_pc_next;
            r_halted <= Halt;
        end
    end

    assign PC       = r_pc;
    assign LinkAddr = w_pc_inc;
    assign Halted   = r_halted;

    // ------------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ButtonRaw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Press detector
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic       r_pulse;

`ifdef JUPS_DEBOUNCE_EN
    localparam logic [1:0] c_ST_ARM = 2'd1;
    localparam int c_CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    // The IDLE edge that first sees s2 high is the first stable sample, so
    // ARM needs DEB_CYCLES-1 further samples: it fires when the count that
    // started at zero on entry has reached DEB_CYCLES-2.
    localparam logic [c_CNT_W-1:0] c_ARM_LAST  = c_CNT_W'(DEB_CYCLES - 2);
    // HELD clears the count on entry and needs DEB_CYCLES low samples.
    localparam logic [c_CNT_W-1:0] c_HELD_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= c_ST_ARM;
                        r_cnt   <= '0;
                    end
                end
                c_ST_ARM: begin
                    if (!r_sync2) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_ARM_LAST) begin
                        r_state <= c_ST_HELD;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_HELD: begin
                    if (r_sync2) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_HELD_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
`else
    // Without the counter the threshold is effectively one cycle.
    localparam int c_unused_deb_cycles = DEB_CYCLES;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= c_ST_HELD;
                        r_pulse <= 1'b1;
                    end
                end
                c_ST_HELD: begin
                    if (!r_sync2) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
`endif

    assign ButtonPulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_jups_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_jups_fetch_pc
// Description : Scoreboard bench for jups_fetch_pc. The stimulus process
//               queues the expected PC / ButtonPulse / Halted after every
//               edge; the monitor pops and compares one entry per edge.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_jups_fetch_pc;

    localparam int PW  = 10;
    localparam int DEB = 16;
`ifdef JUPS_DEBOUNCE_EN
    localparam int DEB_EFF = DEB;
`else
    localparam int DEB_EFF = 1;
`endif
    // Ticks with the button pressed before the mid-run reset; stays short of
    // the pulse edge in both configurations.
    localparam int ARM_TICKS = (DEB_EFF > 1) ? 4 : 2;
    localparam int TIMEOUT_NS = 100000;

    logic          Clock     = 1'b0;
    logic          Reset     = 1'b1;
    logic          ButtonRaw = 1'b0;
    logic          Halt      = 1'b0;
    logic          Jump      = 1'b0;
    logic          Jal       = 1'b0;
    logic          Jr        = 1'b0;
    logic          branch    = 1'b0;
    logic          Zero      = 1'b0;
    logic [PW-1:0] Target    = '0;
    logic [PW-1:0] RegTarget = '0;
    logic [PW-1:0] PC;
    logic [PW-1:0] LinkAddr;
    logic          ButtonPulse;
    logic          Halted;

    always #5 Clock = ~Clock;

    jups_fetch_pc #(
        .PC_WIDTH   (PW),
        .RESET_PC   (0),
        .DEB_CYCLES (DEB)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ButtonRaw   (ButtonRaw),
        .Halt        (Halt),
        .Jump        (Jump),
        .Jal         (Jal),
        .Jr          (Jr),
        .branch      (branch),
        .Zero        (Zero),
        .Target      (Target),
        .RegTarget   (RegTarget),
        .PC          (PC),
        .LinkAddr    (LinkAddr),
        .ButtonPulse (ButtonPulse),
        .Halted      (Halted)
    );

    typedef struct {
        string         name;
        logic [PW-1:0] pc;
        logic          pulse;
        logic          halted;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    event chk_now;

    task automatic expect_state(input string name, input logic [PW-1:0] pc,
                                input logic pulse, input logic halted);
        exp_t e;
        e.name   = name;
        e.pc     = pc;
        e.pulse  = pulse;
        e.halted = halted;
        q.push_back(e);
    endtask

    // Inputs are already set; queue the state expected after the next edge.
    task automatic tick(input string name, input logic [PW-1:0] pc,
                        input logic pulse, input logic halted);
        expect_state(name, pc, pulse, halted);
        @(negedge Clock);
    endtask

    task automatic set_ctl(input logic h, input logic jr_i, input logic j,
                           input logic jl, input logic br, input logic z,
                           input logic [PW-1:0] tg, input logic [PW-1:0] rt);
        Halt      = h;
        Jr        = jr_i;
        Jump      = j;
        Jal       = jl;
        branch    = br;
        Zero      = z;
        Target    = tg;
        RegTarget = rt;
    endtask

    // Monitor: one expected entry per edge, or on demand for async checks.
    initial begin : monitor
        exp_t          e;
        logic [PW-1:0] link_exp;
        forever begin
            @(posedge Clock or chk_now);
            #1;
            if (q.size() > 0) begin
                e        = q.pop_front();
                link_exp = e.pc + PW'(1);
                n_tests++;
                if (PC !== e.pc || LinkAddr !== link_exp ||
                    ButtonPulse !== e.pulse || Halted !== e.halted) begin
                    n_fail++;
                    $display("FAIL %s: got PC=%h LinkAddr=%h ButtonPulse=%b Halted=%b, expected PC=%h LinkAddr=%h ButtonPulse=%b Halted=%b",
                             e.name, PC, LinkAddr, ButtonPulse, Halted,
                             e.pc, link_exp, e.pulse, e.halted);
                end
            end
        end
    end

    // Watchdog: the stimulus must finish within the time bound.
    initial begin : watchdog
        #(TIMEOUT_NS);
        n_fail++;
        $display("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stimulus
        // Asynchronous reset before any clock edge.
        #1 Reset = 1'b0;
        #1;
        n_tests++;
        if (PC !== 10'h000 || LinkAddr !== 10'h001 ||
            ButtonPulse !== 1'b0 || Halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got PC=%h LinkAddr=%h ButtonPulse=%b Halted=%b, expected PC=000 LinkAddr=001 ButtonPulse=0 Halted=0",
                     PC, LinkAddr, ButtonPulse, Halted);
        end
        expect_state("async_reset", 10'h000, 1'b0, 1'b0);
        -> chk_now;
        @(negedge Clock);

        for (int i = 0; i < 3; i++) tick("reset_hold", 10'h000, 1'b0, 1'b0);
        Reset = 1'b1;
        for (int i = 1; i <= 5; i++) tick("reset_release_count", PW'(i), 1'b0, 1'b0);

        // Jump and link.
        set_ctl(0, 0, 1, 0, 0, 0, 10'h010, 10'h000); tick("jump_to_010",        10'h010, 1'b0, 1'b0);
        set_ctl(0, 0, 1, 1, 0, 0, 10'h200, 10'h000); tick("jal_to_200",         10'h200, 1'b0, 1'b0);

        // Priority and branch.
        set_ctl(1, 1, 1, 0, 0, 0, 10'h123, 10'h055); tick("halt_over_jr_jump",  10'h200, 1'b0, 1'b1);
        set_ctl(0, 1, 1, 0, 0, 0, 10'h123, 10'h055); tick("jr_over_jump",       10'h055, 1'b0, 1'b0);
        set_ctl(0, 0, 0, 0, 1, 0, 10'h100, 10'h055); tick("branch_not_taken",   10'h056, 1'b0, 1'b0);
        set_ctl(0, 0, 0, 0, 1, 1, 10'h100, 10'h000); tick("branch_taken",       10'h100, 1'b0, 1'b0);
        set_ctl(0, 0, 0, 0, 0, 1, 10'h2AA, 10'h000); tick("zero_without_branch",10'h101, 1'b0, 1'b0);

        // Wrap-around.
        set_ctl(0, 0, 1, 0, 0, 0, 10'h3FE, 10'h000); tick("jump_to_3fe",        10'h3FE, 1'b0, 1'b0);
        set_ctl(0, 0, 0, 0, 0, 0, 10'h000, 10'h000); tick("step_to_3ff",        10'h3FF, 1'b0, 1'b0);
        tick("wrap_to_000", 10'h000, 1'b0, 1'b0);
        set_ctl(1, 0, 0, 0, 1, 1, 10'h155, 10'h000); tick("halt_over_branch",   10'h000, 1'b0, 1'b1);
        set_ctl(0, 0, 0, 0, 0, 0, 10'h000, 10'h000); tick("resume_after_halt",  10'h001, 1'b0, 1'b0);

        // Button bouncing with 3-cycle runs while the core waits on Halt.
        // Debounced: no run is long enough. Undebounced: each rise before
        // edge 6k+1 pulses after edge 6k+3.
        set_ctl(1, 0, 0, 0, 0, 0, 10'h000, 10'h000);
        for (int n = 1; n <= 30; n++) begin
            ButtonRaw = (((n - 1) / 3) % 2 == 0);
            tick("bounce", 10'h001, (DEB_EFF == 1) && (n % 6 == 3), 1'b1);
        end
        // Stable rise before edge 31: pulse after edge 31+1+DEB_EFF.
        ButtonRaw = 1'b1;
        for (int n = 31; n <= 70; n++) tick("stable_press", 10'h001, n == 32 + DEB_EFF, 1'b1);
        for (int n = 0; n < 100; n++) tick("held_no_repeat", 10'h001, 1'b0, 1'b1);
        ButtonRaw = 1'b0;
        for (int n = 0; n < 40; n++) tick("release", 10'h001, 1'b0, 1'b1);

        // Reset in the middle of a press.
        set_ctl(0, 0, 1, 0, 0, 0, 10'h123, 10'h000); tick("jump_to_123", 10'h123, 1'b0, 1'b0);
        set_ctl(1, 0, 0, 0, 0, 0, 10'h000, 10'h000);
        ButtonRaw = 1'b1;
        for (int n = 1; n <= ARM_TICKS; n++) tick("press_before_reset", 10'h123, 1'b0, 1'b1);
        #2 Reset = 1'b0;
        set_ctl(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
        #1 expect_state("reset_mid_op", 10'h000, 1'b0, 1'b0);
        -> chk_now;
        @(negedge Clock);
        tick("reset_mid_hold", 10'h000, 1'b0, 1'b0);
        Reset = 1'b1;
        // Button held through release: fresh press, pulse after edge 2+DEB_EFF.
        for (int n = 1; n <= 40; n++) tick("press_through_reset", PW'(n), n == 2 + DEB_EFF, 1'b0);
        for (int n = 41; n <= 100; n++) tick("held_after_reset", PW'(n), 1'b0, 1'b0);

        repeat (2) @(negedge Clock);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected entries never checked", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
